bit_scan_encoder: RTL and testbench
===================================

// Module: bit_scan_encoder
// PURPOSE
//   Converts a WIDTH-bit request bitmap into a stream of SIZE-bit binary indices, one per set bit,
//   lowest index first. Inverse direction of the one-hot decoder: decoder expands index->bitmap,
//   this block serialises bitmap->indices. Used for walking valid/dirty/pending masks
//   (e.g. regfile or queue slot masks). valid/ready handshake on both sides.
// PARAMETERS
//   SIZE   3          index width in bits
//   WIDTH  1<<SIZE    bitmap width; must equal 1<<SIZE
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      bitmap offered
//   in_ready   out  1      block accepts bitmap this cycle
//   in_bits    in   WIDTH  request bitmap
//   out_valid  out  1      index beat valid
//   out_ready  in   1      downstream accepts beat
//   out_idx    out  SIZE   binary index of current set bit
//   out_last   out  1      final beat for current bitmap
//   out_none   out  1      beat reports an all-zero bitmap
// BEHAVIOUR
//   - States: IDLE, SCAN, NONE. Reset -> IDLE, pending=0; out_valid/out_last/out_none/out_idx=0.
//   - in_ready = (state==IDLE) & ~rst; no overlap: bitmap N+1 accepted only after last beat of N.
//   - IDLE, in_valid&in_ready: in_bits!=0 -> pending<=in_bits, ->SCAN; in_bits==0 -> ->NONE.
//   - Latency: first beat out_valid on cycle after acceptance edge.
//   - SCAN: out_valid=1; out_idx=priority-encode(pending) (lowest set bit);
//     out_last=1 iff pending has exactly one bit set; out_none=0.
//   - SCAN, out_valid&out_ready: clear pending[out_idx]; if out_last -> IDLE, else stay SCAN.
//     Throughput 1 index/cycle with out_ready held high.
//   - out_ready=0: out_idx/out_last held stable, pending unchanged (AXI-style, no retraction).
//   - NONE: out_valid=1, out_none=1, out_last=1, out_idx=0; on handshake -> IDLE.
//   - in_valid while not IDLE: ignored, no state change (in_ready=0).
//   - rst asserted mid-operation: immediate return to IDLE, pending cleared, out_valid drops
//     asynchronously; unemitted bits discarded.
//   - All outputs derive from state/pending registers only; no combinational in->out path.
// CONFIGURATION
//   BIT_SCAN_HIGH_FIRST_EN defined: scan order highest set bit first (out_idx = MSB of pending).
//   Undefined (default): lowest set bit first. Handshake, out_last, out_none unchanged either way.
// STRUCTURE
//   - Package bit_scan_pkg: state enum typedef (IDLE/SCAN/NONE), localparam for reset index 0.
//   - Sub-module priority_encoder #(SIZE): combinational WIDTH->SIZE encoder plus 'any' flag,
//     direction selected by parameter driven from BIT_SCAN_HIGH_FIRST_EN.
//   - Top: FSM, pending register, one-bit-left detect (pending & (pending-1)) == 0.
// TESTING (SIZE=3)
//   - in_bits=8'b1010_0100, out_ready=1 -> idx 2,5,7 on 3 consecutive cycles, last only on 7;
//     in_ready=1 cycle after idx 7 handshake.
//   - in_bits=8'h00 -> one beat out_none=1 out_last=1 out_idx=0, then IDLE.
//   - in_bits=8'hFF, out_ready=1 -> idx 0..7, 8 beats; with BIT_SCAN_HIGH_FIRST_EN -> 7..0.
//   - in_bits=8'h12, out_ready low 4 cycles -> out_idx=1 held stable, then 1,4 on release.
//   - rst pulse after 2nd beat of 8'hFF -> out_valid=0 at once; after release in_ready=1,
//     new bitmap 8'h80 -> single beat idx 7 last=1.
//   - in_valid with 8'h01 during SCAN -> not accepted; accepted once back in IDLE.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// Shared types for the bit-scan encoder.
//   state_e  : FSM state encoding (IDLE / SCAN / NONE)
//   RST_IDX  : index value presented while no set bit is being reported
package bit_scan_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_NONE = 2'd2
  } state_e;

  localparam int unsigned RST_IDX = 0;
endpackage

// File: rtl/bit_scan_encoder_priority_encoder.sv
// Combinational WIDTH -> SIZE priority encoder with an 'any bit set' flag.
//   bits_i : bitmap to encode
//   idx_o  : index of the lowest set bit (HIGH_FIRST=0) or highest (HIGH_FIRST=1);
//            0 when no bit is set
//   any_o  : at least one bit of bits_i is set
module priority_encoder #(
  parameter int SIZE       = 3,
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic [(1<<SIZE)-1:0] bits_i,
  output logic [SIZE-1:0]      idx_o,
  output logic                 any_o
);
  localparam int WIDTH = 1 << SIZE;

  // The loop direction is chosen so the winning bit is the one assigned last.
  always_comb begin
    idx_o = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (bits_i[i]) idx_o = SIZE'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (bits_i[i]) idx_o = SIZE'(i);
    end
  end

  assign any_o = |bits_i;
endmodule

// File: rtl/bit_scan_encoder.sv
// Serialises a WIDTH-bit request bitmap into a stream of SIZE-bit indices,
// one beat per set bit. An all-zero bitmap yields a single out_none beat.
// valid/ready handshake on both sides; one bitmap in flight at a time.
//   clk, rst              : clock (rising edge), async active-high reset
//   in_valid/in_ready     : bitmap handshake, in_bits = bitmap
//   out_valid/out_ready   : index beat handshake
//   out_idx               : index of the set bit reported this beat
//   out_last              : final beat for the current bitmap
//   out_none              : beat reports an all-zero bitmap
// Build option: define BIT_SCAN_HIGH_FIRST_EN to emit the highest set bit
// first instead of the lowest.
module bit_scan_encoder
  import bit_scan_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_idx,
  output logic             out_last,
  output logic             out_none
);
`ifdef BIT_SCAN_HIGH_FIRST_EN
  localparam bit HIGH_FIRST = 1'b1;
`else
  localparam bit HIGH_FIRST = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [SIZE-1:0]  enc_idx;
  logic             enc_any;
  logic             one_left;

  priority_encoder #(
    .SIZE       (SIZE),
    .HIGH_FIRST (HIGH_FIRST)
  ) u_enc (
    .bits_i (pending_q),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  // Clearing the lowest set bit leaves zero iff at most one bit was set;
  // enc_any rules out the empty case.
  assign one_left = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_bits != '0) begin
            pending_d = in_bits;
            state_d   = ST_SCAN;
          end else begin
            state_d   = ST_NONE;
          end
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          pending_d[enc_idx] = 1'b0;
          if (one_left) state_d = ST_IDLE;
        end
      end
      ST_NONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Outputs come from registered state only; reset clears them immediately.
  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = (state_q == ST_SCAN) | (state_q == ST_NONE);
  assign out_idx   = (state_q == ST_SCAN) ? enc_idx : SIZE'(RST_IDX);
  assign out_last  = ((state_q == ST_SCAN) & one_left) | (state_q == ST_NONE);
  assign out_none  = (state_q == ST_NONE);
endmodule

// File: tb/tb_bit_scan_encoder.sv
module tb_bit_scan_encoder;
  localparam int SIZE  = 3;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_idx;
  logic             out_last;
  logic             out_none;

  bit_scan_encoder #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SIZE-1:0] idx;
    logic            last;
    logic            none;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

`ifdef BIT_SCAN_HIGH_FIRST_EN
  localparam bit HF = 1'b1;
`else
  localparam bit HF = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic ex(input int idx, input bit last, input bit none);
    beat_t b;
    b.idx  = SIZE'(idx);
    b.last = last;
    b.none = none;
    exp_q.push_back(b);
  endtask

  // Monitor: compare every handshaken beat against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got idx=%0d last=%0b none=%0b expected no beat",
                 out_idx, out_last, out_none);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_idx !== e.idx || out_last !== e.last || out_none !== e.none) begin
          n_bad++;
          $display("FAIL beat: got idx=%0d last=%0b none=%0b expected idx=%0d last=%0b none=%0b",
                   out_idx, out_last, out_none, e.idx, e.last, e.none);
        end
      end
    end
  end

  // Offer a bitmap until accepted; returns 1 time unit after the acceptance edge.
  task automatic send(input logic [WIDTH-1:0] bits);
    int n;
    in_valid = 1'b1;
    in_bits  = bits;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || !in_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Count negedges after acceptance until in_ready returns.
  task automatic cycles_to_ready(output int c);
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (in_ready) break;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_none",  out_none,  0);
    chk("rst_out_idx",   out_idx,   0);
    chk("rst_in_ready",  in_ready,  0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1010_0100: three beats back to back, in_ready returns after the last
    if (HF) begin ex(7, 0, 0); ex(5, 0, 0); ex(2, 1, 0); end
    else    begin ex(2, 0, 0); ex(5, 0, 0); ex(7, 1, 0); end
    send(8'b1010_0100);
    cycles_to_ready(c);
    chk("a4_cycles", c, 4);
    drain();

    // all-zero bitmap
    ex(0, 1, 1);
    send(8'h00);
    drain();

    // all ones: 8 beats at full rate
    for (int i = 0; i < 8; i++) ex(HF ? 7 - i : i, i == 7, 0);
    send(8'hFF);
    cycles_to_ready(c);
    chk("ff_cycles", c, 9);
    drain();

    // backpressure: first index held stable
    out_ready = 1'b0;
    if (HF) begin ex(4, 0, 0); ex(1, 1, 0); end
    else    begin ex(1, 0, 0); ex(4, 1, 0); end
    send(8'h12);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_idx", out_idx, HF ? 4 : 1);
      chk("hold_last", out_last, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // reset after the second beat of 8'hFF
    ex(HF ? 7 : 0, 0, 0); ex(HF ? 6 : 1, 0, 0);
    send(8'hFF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_leftover", exp_q.size(), 0);
    @(posedge clk); #1;
    ex(7, 1, 0);
    send(8'h80);
    drain();

    // bitmap offered during SCAN is held off until IDLE
    out_ready = 1'b0;
    if (HF) begin ex(1, 0, 0); ex(0, 1, 0); end
    else    begin ex(0, 0, 0); ex(1, 1, 0); end
    ex(0, 1, 0);
    send(8'h03);
    in_valid = 1'b1; in_bits = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      chk("busy_idx", out_idx, HF ? 1 : 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h01);
    drain();

    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end
endmodule
